// File: rtl/pattern_det_pkg.sv
// Shared types and constants for the serial pattern detector.
package pattern_det_pkg;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Configuration loaded by reset: detect 101, length 3, overlapping, run until stop.
  localparam int         RST_PATTERN = 5;
  localparam logic [3:0] RST_LEN     = 4'd3;
  localparam logic       RST_OVERLAP = 1'b1;
  localparam int         RST_TARGET  = 0;

endpackage

// File: rtl/pattern_shreg.sv
// History shift register, saturating valid-bit counter and masked pattern compare.
// hit is combinational and reflects the history as it will be after this cycle's shift.
module pattern_shreg #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       len,
  output logic             hit
);

  localparam int BW = $clog2(PAT_W + 1);
  localparam int CW = (BW > 4) ? BW : 4;

  logic [PAT_W-1:0] hist_reg, hist_next, mask;
  logic [BW-1:0]    seen_reg, seen_next;

  // Post-shift history/count and the compare against the low len bits of the pattern.
  always_comb begin
    hist_next = {hist_reg[PAT_W-2:0], din};
    seen_next = (seen_reg == BW'(PAT_W)) ? seen_reg : seen_reg + BW'(1);
    mask      = ~({PAT_W{1'b1}} << len);
    hit       = shift && (CW'(seen_next) >= CW'(len)) &&
                (((hist_next ^ pattern) & mask) == '0);
  end

  // History and bit count; non-overlap mode restarts the count after a match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg <= '0;
      seen_reg <= '0;
    end else if (clear) begin
      hist_reg <= '0;
      seen_reg <= '0;
    end else if (shift) begin
      hist_reg <= hist_next;
      seen_reg <= (hit && !overlap) ? '0 : seen_next;
    end
  end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Run-control FSM, shadow configuration and match counter for the serial pattern detector.
module pattern_det_ctrl #(
  parameter int PAT_W = pattern_det_pkg::PAT_W,
  parameter int CNT_W = pattern_det_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             din_valid,
  input  logic             din,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             cfg_err
);

  import pattern_det_pkg::*;

  state_t           state_reg, state_next;
  logic [PAT_W-1:0] pattern_reg;
  logic [3:0]       len_reg;
  logic             overlap_reg;
  logic [CNT_W-1:0] target_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             match_reg, cfg_err_reg;
  logic             shift, clear, hit, len_ok, cfg_load;

  pattern_shreg #(.PAT_W(PAT_W)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .shift   (shift),
    .din     (din),
    .overlap (overlap_reg),
    .pattern (pattern_reg),
    .len     (len_reg),
    .hit     (hit)
  );

  // Next state, run entry and counter update; stop always dominates start.
  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    shift      = (state_reg == RUN) && din_valid;
    cnt_inc    = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
    case (state_reg)
      IDLE, DONE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          state_next = RUN;
          clear      = 1'b1;
        end
      end
      RUN: begin
        if (stop)
          state_next = IDLE;
        else if (hit && (target_reg != '0) && (cnt_inc == target_reg))
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    if (clear)
      cnt_next = '0;
    else if (hit)
      cnt_next = cnt_inc;
    else
      cnt_next = cnt_reg;
    len_ok   = (32'(cfg_len) >= 2) && (32'(cfg_len) <= PAT_W);
    cfg_load = cfg_we && (state_reg != RUN) && len_ok;
  end

  // State, counter and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      match_reg   <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      match_reg   <= hit;
      cfg_err_reg <= cfg_we && !cfg_load;
    end
  end

  // Shadow configuration, written only outside RUN with a legal length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_reg <= PAT_W'(RST_PATTERN);
      len_reg     <= RST_LEN;
      overlap_reg <= RST_OVERLAP;
      target_reg  <= CNT_W'(RST_TARGET);
    end else if (cfg_load) begin
      pattern_reg <= cfg_pattern;
      len_reg     <= cfg_len;
      overlap_reg <= cfg_overlap;
      target_reg  <= cfg_target;
    end
  end

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign match     = match_reg;
  assign match_cnt = cnt_reg;
  assign cfg_err   = cfg_err_reg;

endmodule

// File: doc/pattern_det_ctrl.md
PATTERN_DET_CTRL -- requirements
Module: pattern_det_ctrl

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8: width of the match counter and the target.
REQ-003 clk  input  1  clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 cfg_we  input  1  one-cycle configuration write strobe.
REQ-006 cfg_pattern  input  PAT_W  pattern bits; bit 0 is the most recent serial bit.
REQ-007 cfg_len  input  4  pattern length; legal range 2..PAT_W.
REQ-008 cfg_overlap  input  1  1 = overlapping detection; 0 = non-overlapping detection.
REQ-009 cfg_target  input  CNT_W  match count that ends a run; 0 = run until stop.
REQ-010 start  input  1  one-cycle pulse that begins a run.
REQ-011 stop  input  1  one-cycle pulse that aborts a run.
REQ-012 din_valid  input  1  qualifies din.
REQ-013 din  input  1  serial data bit.
REQ-014 busy  output  1  high while in RUN.
REQ-015 match  output  1  one-cycle registered match pulse.
REQ-016 match_cnt  output  CNT_W  matches counted in the current run.
REQ-017 done  output  1  high while in DONE.
REQ-018 cfg_err  output  1  one-cycle pulse on a rejected configuration write.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-020 IDLE->RUN on start; RUN->DONE when a match brings match_cnt to cfg_target (target != 0); RUN->IDLE on stop; DONE->RUN on start; DONE->IDLE on stop.
REQ-021 cfg_we SHALL load the shadow registers (pattern, len, overlap, target) only in IDLE or DONE and only when 2 <= cfg_len <= PAT_W.
REQ-022 cfg_we in RUN, or with an illegal cfg_len, SHALL leave the configuration unchanged and pulse cfg_err on the next cycle.
REQ-023 Entering RUN SHALL clear the history register, the valid-bit count (bits_seen, saturating at PAT_W) and match_cnt.
REQ-024 In RUN, each din_valid cycle SHALL shift din into history bit 0 and increment bits_seen; cycles with din_valid low SHALL hold all state.
REQ-025 A match SHALL be detected when bits_seen >= len and history[len-1:0] == pattern[len-1:0], both evaluated after the shift; match SHALL be high exactly one cycle after the completing bit.
REQ-026 In overlap mode the history SHALL be kept after a match; in non-overlap mode bits_seen SHALL be cleared to 0 after a match.
REQ-027 match_cnt SHALL increment on each match and saturate at all-ones; a target of 0 SHALL never trigger DONE.
REQ-028 In DONE, din SHALL be ignored, and match_cnt and done SHALL hold.
REQ-029 If stop and start are asserted together, stop SHALL win.
REQ-030 If stop and a match occur in the same cycle, the match SHALL be counted and the FSM SHALL go to IDLE.

Reset
REQ-031 rst SHALL force IDLE, clear the history and bits_seen, and drive busy, match, match_cnt, done and cfg_err to 0.
REQ-032 rst SHALL set the configuration to pattern=3'b101 (zero-extended), len=3, overlap=1, target=0.
REQ-033 rst asserted mid-run SHALL abort the run immediately and discard any in-flight match pulse.

Structure
REQ-034 Package pattern_det_pkg SHALL hold the state enum, PAT_W, CNT_W and the reset configuration constants.
REQ-035 Sub-module pattern_shreg SHALL implement the history shift register, the bits_seen counter and the masked compare.
REQ-036 pattern_det_ctrl SHALL own the FSM, the shadow configuration registers and the match counter.

Verification
REQ-037 Reset config; start; din 1,0,1,0,1 -> match pulses after bits 3 and 5, match_cnt=2, busy=1.
REQ-038 cfg_overlap=0, len=3, pattern 101; din 1,0,1,0,1 -> exactly one match, match_cnt=1.
REQ-039 cfg_target=2, pattern 11, len=2; din 1,1,1 -> matches after bits 2 and 3, then done=1, busy=0; further din ignored.
REQ-040 cfg_we during RUN, or cfg_len=1 or 9 in IDLE -> cfg_err pulse, configuration unchanged.
REQ-041 rst during RUN with match_cnt=3 -> all outputs 0, state IDLE, next start counts from 0.
REQ-042 stop together with start in IDLE -> stays IDLE; stop coinciding with a match -> match_cnt increments, then IDLE.
